// File: rtl/sequence_pkg.sv
// Shared definitions for the sequence link (generator and detector).
//   state_t         : generator FSM states
//   DEFAULT_PATTERN : pattern register value after reset
package sequence_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

endpackage

// File: rtl/sequence_generator_moore_if.sv
// Control/status bundle of the serial pattern generator.
//   master : burst requester (drives start/pattern/repeat_count/gap_cycles)
//   slave  : generator (drives ready/busy/sequence_out/frame_start/done)
interface sequence_generator_moore_if #(
  parameter int PATTERN_W = 4,
  parameter int COUNT_W   = 8,
  parameter int GAP_W     = 4
);

  logic                 start;
  logic [PATTERN_W-1:0] pattern;
  logic [COUNT_W-1:0]   repeat_count;
  logic [GAP_W-1:0]     gap_cycles;
  logic                 ready;
  logic                 busy;
  logic                 sequence_out;
  logic                 frame_start;
  logic                 done;

  modport master (
    output start, pattern, repeat_count, gap_cycles,
    input  ready, busy, sequence_out, frame_start, done
  );

  modport slave (
    input  start, pattern, repeat_count, gap_cycles,
    output ready, busy, sequence_out, frame_start, done
  );

endinterface

// File: rtl/sequence_serializer.sv
// Loadable MSB-first shift register with a bit counter.
//   clock, reset : system clock, synchronous active-high reset
//   load         : capture load_value, bit counter = PATTERN_W-1
//   shift        : shift left one bit, decrement bit counter
//   load_value   : parallel value captured on load
//   serial_out   : current MSB
//   last_bit     : bit counter is 0 (final bit of the word is on serial_out)
module sequence_serializer #(
  parameter int                   PATTERN_W   = 4,
  parameter logic [PATTERN_W-1:0] RESET_VALUE = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 shift,
  input  logic [PATTERN_W-1:0] load_value,
  output logic                 serial_out,
  output logic                 last_bit
);

  localparam int CNT_W = (PATTERN_W > 2) ? $clog2(PATTERN_W) : 1;

  logic [PATTERN_W-1:0] shift_reg;
  logic [CNT_W-1:0]     bit_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      shift_reg <= RESET_VALUE;
      bit_cnt   <= '0;
    end else if (load) begin
      shift_reg <= load_value;
      bit_cnt   <= CNT_W'(PATTERN_W - 1);
    end else if (shift) begin
      shift_reg <= {shift_reg[PATTERN_W-2:0], 1'b0};
      bit_cnt   <= bit_cnt - CNT_W'(1);
    end
  end

  assign serial_out = shift_reg[PATTERN_W-1];
  assign last_bit   = (bit_cnt == '0);

endmodule

// File: rtl/sequence_generator_moore.sv
// Serial pattern generator: emits a captured pattern MSB-first for a
// programmable number of repetitions with an optional idle gap between them.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : start/pattern/repeat_count/gap_cycles in,
//                  ready/busy/sequence_out/frame_start/done out
// All status outputs are flops loaded from the next state, so they depend on
// registered state only.
module sequence_generator_moore #(
  parameter int                   PATTERN_W       = 4,
  parameter int                   COUNT_W         = 8,
  parameter int                   GAP_W           = 4,
  parameter logic [PATTERN_W-1:0] DEFAULT_PATTERN = PATTERN_W'(sequence_pkg::DEFAULT_PATTERN)
) (
  input  logic                        clock,
  input  logic                        reset,
  sequence_generator_moore_if.slave   bus
);

  import sequence_pkg::*;

  state_t               state, state_d;
  logic [PATTERN_W-1:0] reload_reg;
  logic [COUNT_W-1:0]   rep_cnt;
  logic [GAP_W-1:0]     gap_reload;
  logic [GAP_W-1:0]     gap_cnt;
  logic                 in_shift;

  logic                 ser_load, ser_shift, ser_out, last_bit;
  logic [PATTERN_W-1:0] ser_value;
  logic                 frame_d;

  sequence_serializer #(
    .PATTERN_W   (PATTERN_W),
    .RESET_VALUE (DEFAULT_PATTERN)
  ) u_ser (
    .clock      (clock),
    .reset      (reset),
    .load       (ser_load),
    .shift      (ser_shift),
    .load_value (ser_value),
    .serial_out (ser_out),
    .last_bit   (last_bit)
  );

  // Next-state and serializer control.
  always_comb begin
    state_d   = state;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    ser_value = reload_reg;
    unique case (state)
      IDLE: if (bus.start) begin
        ser_load  = 1'b1;
        ser_value = bus.pattern;
        state_d   = (bus.repeat_count != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        if (last_bit) begin
          if (rep_cnt == COUNT_W'(1)) begin
            state_d = DONE;
          end else begin
            // Reload now so the word is ready whether or not a gap follows.
            ser_load = 1'b1;
            state_d  = (gap_reload != '0) ? GAP : SHIFT;
          end
        end else begin
          ser_shift = 1'b1;
        end
      end
      GAP:  if (gap_cnt == '0) state_d = SHIFT;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A fresh word is on the serializer whenever SHIFT is entered from
    // another state or re-entered after the last bit of a repetition.
    frame_d = (state_d == SHIFT) && ((state != SHIFT) || last_bit);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      reload_reg      <= DEFAULT_PATTERN;
      rep_cnt         <= '0;
      gap_reload      <= '0;
      gap_cnt         <= '0;
      in_shift        <= 1'b0;
      bus.ready       <= 1'b1;
      bus.busy        <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      state <= state_d;
      unique case (state)
        IDLE: if (bus.start) begin
          reload_reg <= bus.pattern;
          rep_cnt    <= bus.repeat_count;
          gap_reload <= bus.gap_cycles;
        end
        SHIFT: if (last_bit) begin
          rep_cnt <= rep_cnt - COUNT_W'(1);
          gap_cnt <= gap_reload - GAP_W'(1);
        end
        GAP: if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
        default: ;
      endcase
      in_shift        <= (state_d == SHIFT);
      bus.ready       <= (state_d == IDLE);
      bus.busy        <= (state_d != IDLE);
      bus.frame_start <= frame_d;
      bus.done        <= (state_d == DONE);
    end
  end

  assign bus.sequence_out = ser_out & in_shift;

endmodule

// File: doc/sequence_generator_moore.md
# sequence_generator_Moore

Serial pattern generator that drives a single-bit stream into the sequence detector's `sequence_in`. It captures a programmable PATTERN_W-bit pattern and emits it MSB-first, one bit per clock, for a programmable number of repetitions with an optional idle gap between repetitions. It is the transmit side of the sequence link, used as the stimulus source in system-level loops and as an on-chip pattern source. Outputs are Moore-style: every output is a function of registered state only.

## Interface
Parameters:
- PATTERN_W, 4, pattern length in bits (≥2)
- COUNT_W, 8, width of repeat count
- GAP_W, 4, width of inter-pattern gap count
- DEFAULT_PATTERN, 4'b1011, pattern register value after reset

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request a burst; sampled only when ready=1
- pattern  in  PATTERN_W  pattern to emit, MSB transmitted first
- repeat_count  in  COUNT_W  number of pattern repetitions (0 = emit nothing)
- gap_cycles  in  GAP_W  idle cycles (output 0) between repetitions
- ready  out  1  high in IDLE; burst may be started
- busy  out  1  high in SHIFT, GAP, DONE
- sequence_out  out  1  serial data; 0 whenever not in SHIFT
- frame_start  out  1  high during the first bit of each repetition
- done  out  1  one-cycle pulse after the final bit of a burst

## Operation
- States: IDLE, SHIFT, GAP, DONE (encoding in package).
- Reset: state=IDLE, shift register=DEFAULT_PATTERN, counters=0; ready=1, busy=0, sequence_out=0, frame_start=0, done=0.
- IDLE: on edge with start=1: latch pattern into shift register and into a reload register; latch repeat_count into rep counter, gap_cycles into gap reload; bit counter=PATTERN_W-1. Go to SHIFT if repeat_count≠0, else DONE.
- SHIFT: sequence_out = shift_reg[MSB]; each edge shifts left by one and decrements bit counter. frame_start=1 when bit counter = PATTERN_W-1.
- End of repetition (bit counter=0 at edge): decrement rep counter. If result 0 → DONE. Else reload shift register from reload register, bit counter=PATTERN_W-1; go to GAP if gap≠0 (gap counter=gap-1), else stay in SHIFT (back-to-back, no idle bit).
- GAP: sequence_out=0; when gap counter=0 → SHIFT (reloaded), else decrement.
- DONE: done=1, sequence_out=0 for exactly one cycle, then IDLE.
- start while busy: ignored, no queuing. Input changes during a burst have no effect on it.
- Reset asserted mid-burst: next edge forces reset values; no done pulse.

## Timing
- start sampled at edge k → first bit on sequence_out in cycle k+1 (1-cycle latency); ready falls in cycle k+1.
- Burst with R≥1 repetitions, gap G: SHIFT/GAP occupy R·PATTERN_W + (R−1)·G cycles, then DONE 1 cycle, IDLE next; ready high again R·PATTERN_W + (R−1)·G + 2 cycles after the start edge.
- R=0: DONE in cycle k+1, IDLE in k+2; sequence_out stays 0.
- start may be asserted in the DONE cycle; ignored (ready=0). Earliest restart is the first IDLE cycle.
- Counters never wrap: rep counter max 2^COUNT_W−1, gap max 2^GAP_W−1, both exact.

## Structure
- Package `sequence_pkg`: state enum (IDLE, SHIFT, GAP, DONE), DEFAULT_PATTERN constant 4'b1011, shared with the detector.
- One sub-module: `sequence_serializer` — loadable PATTERN_W shift register plus bit counter, with ports load, shift, load_value, serial_out, last_bit. FSM, repeat counter and gap counter live in the top.

## Test plan
- Reset held 3 cycles, then released: ready=1, sequence_out=0, busy=0, done=0 every cycle while reset.
- pattern=4'b1011, R=1, G=0, start one cycle: sequence_out 1,0,1,1 in cycles k+1..k+4, frame_start only at k+1, done at k+5, ready at k+6.
- pattern=1011, R=2, G=0: stream 1,0,1,1,1,0,1,1 contiguous; frame_start at k+1 and k+5; the detector instance pulses detector_out twice.
- pattern=1011, R=3, G=2: bits 1011 00 1011 00 1011, done at k+17; start pulses during burst ignored.
- R=0: no 1s on sequence_out, done at k+1, ready at k+2.
- reset asserted at 2nd bit of R=5 burst: IDLE next edge, sequence_out=0, no done pulse; a new start then behaves as a fresh burst.
